arbitro_nota: RTL and testbench
===============================

ARBITRO_NOTA -- requirements
Module: arbitro_nota

Interface
REQ-001 Parameter HOLD_MIN, default 4: minimum cycles a grant is held once given.
REQ-002 Parameter HOLD_MAX, default 16: grant cycles after which a waiting requester preempts the owner; HOLD_MAX SHALL be greater than or equal to HOLD_MIN, with both in the range 1..255.
REQ-003 Parameter SILENCIO, default 2: silent gap cycles between two grants, range 0..255.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_libre  in  1  free-play requester wants the tone path.
REQ-007 nota_libre  in  3  free-play note code; 0 is silence, 1..4 are notes.
REQ-008 req_cancion  in  1  song-player requester wants the tone path.
REQ-009 nota_cancion  in  3  song-player note code, same encoding as nota_libre.
REQ-010 grant_libre  out  1  free-play requester owns the tone path.
REQ-011 grant_cancion  out  1  song player owns the tone path.
REQ-012 notaSalida  out  3  note code forwarded to the tone generator.
REQ-013 contar  out  1  tone and duration-counter enable.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, GNT_LIBRE, GNT_CANCION and GAP.
REQ-015 grant_libre SHALL be a Moore decode of GNT_LIBRE, and grant_cancion a Moore decode of GNT_CANCION; the two SHALL never be high in the same cycle.
REQ-016 In IDLE, when exactly one request is high, the next state SHALL be that requester's GNT state; with neither high, the state SHALL stay IDLE.
REQ-017 In IDLE with both requests high, the grant SHALL go to the requester that was not granted last (round-robin) and the ultimo flag SHALL be updated on every grant entry.
REQ-018 Hold counter cnt SHALL be 8 bits, SHALL be 0 on the first cycle of a GNT state, SHALL increment by 1 per cycle and SHALL saturate at 255.
REQ-019 A GNT state SHALL be left on the cycle after (owner request low AND cnt >= HOLD_MIN-1), so every grant lasts at least HOLD_MIN cycles even if the request drops earlier.
REQ-020 A GNT state SHALL also be left on the cycle after (other request high AND cnt == HOLD_MAX-1); preemption SHALL apply even while the owner request is still high.
REQ-021 On leaving a GNT state the next state SHALL be GAP if SILENCIO > 0, else IDLE.
REQ-022 GAP SHALL last exactly SILENCIO cycles, reusing cnt from 0, then go to IDLE; requests SHALL be ignored during GAP.
REQ-023 notaSalida and contar SHALL be registered with one-cycle latency: in the cycle after any GNT cycle, notaSalida SHALL equal the owner's nota sampled in that GNT cycle.
REQ-024 contar SHALL be 1 exactly when that sampled nota is nonzero.
REQ-025 In the cycle after any IDLE or GAP cycle, notaSalida SHALL be 0 and contar SHALL be 0.
REQ-026 A nota input of 5..7 SHALL be treated as 0 (silence).

Reset
REQ-027 When reset is high at a clock edge, the state SHALL become IDLE, cnt SHALL become 0 and ultimo SHALL become cancion, so that free-play wins the first tie.
REQ-028 When reset is high at a clock edge, the next cycle SHALL have notaSalida=0, contar=0, grant_libre=0 and grant_cancion=0.
REQ-029 Reset asserted mid-grant or mid-gap SHALL abort it immediately with no gap; reset SHALL take priority over all transitions.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=0, GNT_LIBRE=1, GNT_CANCION=2, GAP=3), the note constants nota0..nota4 and the default values of HOLD_MIN, HOLD_MAX and SILENCIO.
REQ-031 The hold counter SHALL be one sub-module, contador_sat, an 8-bit saturating counter with synchronous clear and enable.

Verification
REQ-032 Single request: req_libre=1 with nota_libre=2 for 10 cycles -> grant_libre high from the cycle after request, notaSalida=2 and contar=1 one cycle later; request drop -> 2 GAP cycles with notaSalida=0.
REQ-033 Minimum hold: req_cancion pulsed for 1 cycle -> grant_cancion high for exactly 4 cycles, then GAP for 2 cycles, then IDLE.
REQ-034 Tie after reset: both requests rise in the same cycle -> libre is granted first; after GAP and IDLE, cancion is granted.
REQ-035 Preemption: libre is held continuously and cancion rises at grant cycle 3 -> libre is released after 16 grant cycles, then GAP for 2 cycles, then grant_cancion.
REQ-036 Reset mid-grant: reset asserted at grant cycle 5 -> the next cycle shows all outputs 0 and state IDLE; a held request is re-granted the cycle after reset deasserts.
REQ-037 Note sanitising: nota_libre=6 while granted -> notaSalida=0 and contar=0.

Source files
------------

// File: rtl/arbitro_nota_pkg.sv
// Shared types and constants for the tone-path arbiter: state encoding,
// note codes, parameter defaults and the note sanitising helper.
package arbitro_nota_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GNT_LIBRE   = 2'd1,
    GNT_CANCION = 2'd2,
    GAP         = 2'd3
  } estado_t;

  typedef enum logic {
    ULT_LIBRE   = 1'b0,
    ULT_CANCION = 1'b1
  } ultimo_t;

  localparam logic [2:0] nota0 = 3'd0;
  localparam logic [2:0] nota1 = 3'd1;
  localparam logic [2:0] nota2 = 3'd2;
  localparam logic [2:0] nota3 = 3'd3;
  localparam logic [2:0] nota4 = 3'd4;

  localparam int HOLD_MIN_DEF = 4;
  localparam int HOLD_MAX_DEF = 16;
  localparam int SILENCIO_DEF = 2;

  localparam int CNT_W = 8;

  // Codes above the highest defined note carry no pitch, so they become silence.
  function automatic logic [2:0] limpiaNota(input logic [2:0] nota);
    return (nota > nota4) ? nota0 : nota;
  endfunction

endpackage

// File: rtl/arbitro_nota_contador_sat.sv
// Saturating up-counter used to time grant holds and the silent gap.
module contador_sat
  import arbitro_nota_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over counting; the count sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/arbitro_nota.sv
// Arbiter sharing one tone generator between free play and the song player,
// with minimum/maximum hold times and a silent gap between owners.
module arbitro_nota
  import arbitro_nota_pkg::*;
#(
  parameter int HOLD_MIN = HOLD_MIN_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int SILENCIO = SILENCIO_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_libre,
  input  logic [2:0] nota_libre,
  input  logic       req_cancion,
  input  logic [2:0] nota_cancion,
  output logic       grant_libre,
  output logic       grant_cancion,
  output logic [2:0] notaSalida,
  output logic       contar
);

  localparam logic [CNT_W-1:0] MinLast = CNT_W'(HOLD_MIN - 1);
  localparam logic [CNT_W-1:0] MaxLast = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] GapLast = CNT_W'(SILENCIO - 1);
  localparam estado_t          AfterGrant = (SILENCIO > 0) ? GAP : IDLE;

  estado_t          state_q, state_d;
  ultimo_t          ultimo_q, ultimo_d;
  logic [2:0]       nota_q, nota_d;
  logic             contar_q, contar_d;
  logic [CNT_W-1:0] cnt;
  logic             cntClr;

  // Every state change restarts the counter, so cnt is 0 on the first cycle of a state.
  assign cntClr = (state_d != state_q);

  contador_sat u_contador (
    .clk   (clk),
    .reset (reset),
    .clr_i (cntClr),
    .en_i  (1'b1),
    .cnt_o (cnt)
  );

  always_comb begin
    state_d  = state_q;
    ultimo_d = ultimo_q;
    unique case (state_q)
      IDLE: begin
        if (req_libre && (!req_cancion || (ultimo_q == ULT_CANCION))) begin
          state_d  = GNT_LIBRE;
          ultimo_d = ULT_LIBRE;
        end else if (req_cancion) begin
          state_d  = GNT_CANCION;
          ultimo_d = ULT_CANCION;
        end
      end
      GNT_LIBRE: begin
        if ((!req_libre && (cnt >= MinLast)) || (req_cancion && (cnt == MaxLast))) begin
          state_d = AfterGrant;
        end
      end
      GNT_CANCION: begin
        if ((!req_cancion && (cnt >= MinLast)) || (req_libre && (cnt == MaxLast))) begin
          state_d = AfterGrant;
        end
      end
      GAP: begin
        if (cnt == GapLast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The note path lags the grant by one cycle and only forwards the owner's note.
  always_comb begin
    nota_d = nota0;
    if (state_q == GNT_LIBRE) begin
      nota_d = limpiaNota(nota_libre);
    end else if (state_q == GNT_CANCION) begin
      nota_d = limpiaNota(nota_cancion);
    end
    contar_d = (nota_d != nota0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ultimo_q <= ULT_CANCION;
      nota_q   <= nota0;
      contar_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ultimo_q <= ultimo_d;
      nota_q   <= nota_d;
      contar_q <= contar_d;
    end
  end

  assign grant_libre   = (state_q == GNT_LIBRE);
  assign grant_cancion = (state_q == GNT_CANCION);
  assign notaSalida    = nota_q;
  assign contar        = contar_q;

endmodule

// File: tb/tb_arbitro_nota.sv
// Scoreboard bench for arbitro_nota: directed per-cycle vectors push expected
// outputs, an independent monitor pops and compares them on the falling edge.
module tb_arbitro_nota;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_libre, req_cancion;
  logic [2:0] nota_libre, nota_cancion;
  logic       grant_libre, grant_cancion;
  logic [2:0] notaSalida;
  logic       contar;

  typedef struct {
    int         cyc;
    logic [5:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   passCount = 0;
  int   checkCount = 0;

  arbitro_nota dut (
    .clk           (clk),
    .reset         (reset),
    .req_libre     (req_libre),
    .nota_libre    (nota_libre),
    .req_cancion   (req_cancion),
    .nota_cancion  (nota_cancion),
    .grant_libre   (grant_libre),
    .grant_cancion (grant_cancion),
    .notaSalida    (notaSalida),
    .contar        (contar)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic applyStimulus(input logic rst, input logic rl, input logic [2:0] nl,
                               input logic rc, input logic [2:0] nc,
                               input logic gl, input logic gc, input logic [2:0] n,
                               input logic c, input string name);
    exp_t e;
    reset        = rst;
    req_libre    = rl;
    nota_libre   = nl;
    req_cancion  = rc;
    nota_cancion = nc;
    e.cyc  = cyc + 1;
    e.exp  = {gl, gc, n, c};
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [5:0] act;
    act = {grant_libre, grant_cancion, notaSalida, contar};
    checkCount++;
    if (act === e.exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s cyc=%0d got gl=%b gc=%b nota=%0d contar=%b expected gl=%b gc=%b nota=%0d contar=%b",
               e.name, cyc, act[5], act[4], act[3:1], act[0],
               e.exp[5], e.exp[4], e.exp[3:1], e.exp[0]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
        checkOutput(sb.pop_front());
      end
    end
  end

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset_hold");

    // Single free-play request held for ten cycles, then dropped.
    applyStimulus(0, 1, 2, 0, 0, 1, 0, 0, 0, "single_grant");
    for (int i = 2; i <= 10; i++) applyStimulus(0, 1, 2, 0, 0, 1, 0, 2, 1, "single_hold");
    applyStimulus(0, 0, 2, 0, 0, 0, 0, 2, 1, "single_release");
    applyStimulus(0, 0, 2, 0, 0, 0, 0, 0, 0, "single_gap1");
    applyStimulus(0, 0, 2, 0, 0, 0, 0, 0, 0, "single_gap2");

    // One-cycle song pulse still gets the full minimum hold.
    applyStimulus(0, 0, 0, 1, 3, 0, 1, 0, 0, "pulse_grant");
    for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 0, 0, 3, 0, 1, 3, 1, "pulse_hold");
    applyStimulus(0, 0, 0, 0, 3, 0, 0, 3, 1, "pulse_release");
    applyStimulus(0, 0, 0, 0, 3, 0, 0, 0, 0, "pulse_gap1");
    applyStimulus(0, 0, 0, 0, 3, 0, 0, 0, 0, "pulse_gap2");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "pulse_idle");

    // Tie after reset: libre first, cancion waits through the gap.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "tie_reset");
    applyStimulus(0, 1, 1, 1, 4, 1, 0, 0, 0, "tie_first_libre");
    for (int i = 2; i <= 4; i++) applyStimulus(0, 0, 1, 1, 4, 1, 0, 1, 1, "tie_libre_hold");
    applyStimulus(0, 0, 1, 1, 4, 0, 0, 1, 1, "tie_libre_release");
    applyStimulus(0, 0, 1, 1, 4, 0, 0, 0, 0, "tie_gap1_ignores_req");
    applyStimulus(0, 0, 1, 1, 4, 0, 0, 0, 0, "tie_gap2_ignores_req");
    applyStimulus(0, 0, 1, 1, 4, 0, 1, 0, 0, "tie_then_cancion");
    applyStimulus(0, 0, 1, 1, 4, 0, 1, 4, 1, "tie_cancion_nota");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "tie_abort_reset");

    // Preemption: libre held, cancion waits from grant cycle 3.
    applyStimulus(0, 1, 1, 0, 0, 1, 0, 0, 0, "pre_grant");
    for (int i = 2; i <= 3; i++) applyStimulus(0, 1, 1, 0, 0, 1, 0, 1, 1, "pre_hold");
    for (int i = 4; i <= 16; i++) applyStimulus(0, 1, 1, 1, 2, 1, 0, 1, 1, "pre_hold_contested");
    applyStimulus(0, 1, 1, 1, 2, 0, 0, 1, 1, "pre_release");
    applyStimulus(0, 1, 1, 1, 2, 0, 0, 0, 0, "pre_gap1");
    applyStimulus(0, 1, 1, 1, 2, 0, 0, 0, 0, "pre_gap2");
    applyStimulus(0, 1, 1, 1, 2, 0, 1, 0, 0, "pre_cancion_grant");
    applyStimulus(0, 1, 1, 1, 2, 0, 1, 2, 1, "pre_cancion_nota");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "pre_reset");

    // Reset in grant cycle 5 aborts with no gap; held request re-granted at once.
    applyStimulus(0, 1, 3, 0, 0, 1, 0, 0, 0, "rst_grant");
    for (int i = 2; i <= 5; i++) applyStimulus(0, 1, 3, 0, 0, 1, 0, 3, 1, "rst_hold");
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, "rst_mid_grant");
    applyStimulus(0, 1, 3, 0, 0, 1, 0, 0, 0, "rst_regrant");
    applyStimulus(0, 1, 3, 0, 0, 1, 0, 3, 1, "rst_regrant_nota");

    // Out-of-range and silent note codes.
    applyStimulus(0, 1, 6, 0, 0, 1, 0, 0, 0, "sanit_6");
    applyStimulus(0, 1, 4, 0, 0, 1, 0, 4, 1, "nota_4");
    applyStimulus(0, 1, 7, 0, 0, 1, 0, 0, 0, "sanit_7");
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 0, "nota_silence");
    applyStimulus(0, 1, 5, 0, 0, 1, 0, 0, 0, "sanit_5");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "final_reset");

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checkCount += sb.size();
      $display("[TB] FAIL scoreboard_drain got %0d entries left expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
